eeg_epoch_features: RTL and testbench
=====================================

# eeg_epoch_features

Streaming feature extractor that sits directly upstream of the sleep-stage ANN classifier. Consumes one EEG channel as a valid/ready stream of signed Q8.8 samples, accumulates statistics over fixed epochs of 2^LOG2_WIN samples, and presents eight registered signed 16-bit features that drive the classifier's feature0..feature7 inputs. Features are held stable from feat_valid until accepted by feat_ready.

## Interface
- LOG2_WIN, 8, log2 of epoch length in samples; legal range 1..12
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid && s_ready
- s_data  in  16  signed Q8.8 sample
- feat_valid  out  1  feature set valid
- feat_ready  in  1  downstream accepts feature set
- feature0..feature7  out  16 each  signed features (indices below)

## Operation
- Clock is one domain; reset is synchronous and active-low.
- States: ACC (accumulating), FIN (finalise/load). Reset → ACC, sample counter 0, accumulators 0, feat_valid 0, all features 0x0000.
- ACC: s_ready=1. Each accepted sample updates accumulators; accepting sample index 2^LOG2_WIN−1 → FIN.
- FIN: s_ready=0. If !feat_valid || feat_ready: load all eight features, set feat_valid=1, clear accumulators/counter/previous-sample flag, → ACC. Else stay in FIN (stall).
- feat_valid clears on feat_valid && feat_ready unless FIN loads on the same edge (load wins; feat_valid stays 1).
- Features (N = 2^LOG2_WIN, accumulators full width, no intermediate overflow):
  - feature0 mean: Σx >>> LOG2_WIN (arithmetic, floor)
  - feature1 mean abs: Σ|x| >> LOG2_WIN (|−32768| = 32768)
  - feature2 mean square Q8.8: Σx² >> (LOG2_WIN+8); accumulator 32+LOG2_WIN bits unsigned
  - feature3 max, feature4 min of epoch
  - feature5 peak-to-peak: max − min (17-bit)
  - feature6 zero crossings: count of consecutive-sample pairs whose sign bits differ; first sample of epoch has no predecessor
  - feature7 line length: Σ|x[n]−x[n−1]| >> LOG2_WIN (17-bit differences)
- Epochs are independent; no state carries across the boundary.
- s_valid gaps mid-epoch are allowed; counter advances only on handshake.
- rst_n low mid-epoch or in FIN: partial epoch discarded, outputs return to reset values.

## Timing
- Last sample accepted on edge k → FIN during cycle k..k+1 → features loaded and feat_valid=1 after edge k+1 (latency 1 cycle, if not stalled).
- Minimum one s_ready=0 cycle per epoch; sustained throughput N samples per N+1 cycles.
- Features and feat_valid are registers; no combinational path from s_* or feat_ready to any output except s_ready (state decode only).

## Configuration
- FEAT_SAT_EN defined: features 1, 2, 5, 6, 7 saturate to 0x7FFF when the final value exceeds 32767 (feature0/3/4 cannot overflow).
- Undefined: features take low 16 bits of the final value (wrap), saving saturation logic.

## Structure
- Package eeg_feat_pkg: state enum {ACC, FIN}, feature index constants FEAT_MEAN..FEAT_LLEN (0..7), SAT_MAX_S16 = 16'h7FFF, LOG2_WIN default.
- One sub-module sat_s16: unsigned wide input → 16-bit output, saturating or truncating per FEAT_SAT_EN; instantiated once per overflow-capable feature.

## Test plan
- LOG2_WIN=2, samples 0x0100,0xFF00,0x0200,0xFE00 → feature0..7 = 0x0000,0x0180,0x0280,0x0200,0xFE00,0x0400,0x0003,0x0240; feat_valid 1 cycle after last accept.
- LOG2_WIN=2, samples 0x7FFF,0x8000,0x7FFF,0x8000 with FEAT_SAT_EN → f0=0xFFFF, f1=0x7FFF, f2=0x7FFF, f5=0x7FFF, f6=0x0003, f7=0x7FFF; without macro → f2=0xFF80, f5=0xFFFF, f7=0xBFFF.
- feat_ready held 0 across two full epochs → second epoch stalls in FIN with s_ready=0, first feature set unchanged; raise feat_ready → second set loaded next edge, feat_valid stays 1.
- Random s_valid gaps (50% duty) over test-1 samples → identical features to test 1.
- rst_n low for one cycle after 2 of 4 samples → outputs 0, feat_valid 0; following clean epoch matches test 1.

Source files
------------

// File: rtl/eeg_feat_pkg.sv
// Shared types and constants for the EEG epoch feature extractor.
// Features saturate when FEAT_SAT_EN is defined (see sat_s16).
package eeg_feat_pkg;

  typedef enum logic {
    ACC = 1'b0,
    FIN = 1'b1
  } state_t;

  localparam int FEAT_MEAN = 0;
  localparam int FEAT_MABS = 1;
  localparam int FEAT_MSQ  = 2;
  localparam int FEAT_MAX  = 3;
  localparam int FEAT_MIN  = 4;
  localparam int FEAT_P2P  = 5;
  localparam int FEAT_ZC   = 6;
  localparam int FEAT_LLEN = 7;

  localparam logic [15:0] SAT_MAX_S16 = 16'h7FFF;
  localparam int LOG2_WIN_DEFAULT = 8;

endpackage

// File: rtl/sat_s16.sv
// Narrows an unsigned feature value to 16 bits: clamps to 0x7FFF when
// FEAT_SAT_EN is defined, otherwise keeps the low 16 bits.
module sat_s16
  import eeg_feat_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] din,
  output logic [15:0]  dout
);

  localparam int XW = (W > 16) ? W : 16;

  logic [XW-1:0] wide;
  assign wide = XW'(din);

`ifdef FEAT_SAT_EN
  assign dout = (wide > XW'(SAT_MAX_S16)) ? SAT_MAX_S16 : wide[15:0];
`else
  assign dout = wide[15:0];

  // Upper bits are intentionally dropped in the wrapping build.
  if (XW > 16) begin : g_sink
    logic unused_hi;
    assign unused_hi = ^wide[XW-1:16];
  end
`endif

endmodule

// File: rtl/eeg_epoch_features.sv
// Streaming per-epoch EEG statistics feeding the sleep-stage classifier.
// Optional saturation of overflow-capable features via FEAT_SAT_EN.
module eeg_epoch_features
  import eeg_feat_pkg::*;
#(
  parameter int LOG2_WIN = LOG2_WIN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        feat_valid,
  input  logic        feat_ready,
  output logic [15:0] feature0,
  output logic [15:0] feature1,
  output logic [15:0] feature2,
  output logic [15:0] feature3,
  output logic [15:0] feature4,
  output logic [15:0] feature5,
  output logic [15:0] feature6,
  output logic [15:0] feature7
);

  localparam int SW = 16 + LOG2_WIN;
  localparam int QW = 32 + LOG2_WIN;
  localparam int ZW = LOG2_WIN + 1;

  state_t state;

  logic [LOG2_WIN-1:0] cnt;
  logic signed [SW-1:0] sum_x;
  logic [SW-1:0]        sum_abs;
  logic [SW-1:0]        sum_llen;
  logic [QW-1:0]        sum_sq;
  logic signed [15:0]   max_x;
  logic signed [15:0]   min_x;
  logic signed [15:0]   prev_x;
  logic                 have_prev;
  logic [ZW-1:0]        zc;

  logic signed [15:0] x;
  logic signed [16:0] xw;
  logic signed [16:0] dw;
  logic [16:0]        xabs;
  logic [16:0]        dabs;
  logic signed [31:0] xsq;
  logic [16:0]        p2p;
  logic               take;
  logic               load;
  logic [15:0]        fnext [8];

  assign s_ready = (state == ACC);
  assign take    = s_valid && s_ready;
  assign load    = (state == FIN) && (!feat_valid || feat_ready);

  assign x    = s_data;
  assign xw   = 17'(x);
  assign xabs = xw[16] ? 17'(-xw) : 17'(xw);
  assign dw   = xw - 17'(prev_x);
  assign dabs = dw[16] ? 17'(-dw) : 17'(dw);
  assign xsq  = x * x;
  assign p2p  = 17'(max_x) - 17'(min_x);

  // Accumulator widths are sized so no epoch sum can overflow before the shift.
  assign fnext[FEAT_MEAN] = sum_x[SW-1:LOG2_WIN];
  assign fnext[FEAT_MAX]  = max_x;
  assign fnext[FEAT_MIN]  = min_x;

  sat_s16 #(.W(16)) u_sat_mabs (.din(sum_abs[SW-1:LOG2_WIN]),      .dout(fnext[FEAT_MABS]));
  sat_s16 #(.W(24)) u_sat_msq  (.din(sum_sq[QW-1:LOG2_WIN+8]),     .dout(fnext[FEAT_MSQ]));
  sat_s16 #(.W(17)) u_sat_p2p  (.din(p2p),                         .dout(fnext[FEAT_P2P]));
  sat_s16 #(.W(ZW)) u_sat_zc   (.din(zc),                          .dout(fnext[FEAT_ZC]));
  sat_s16 #(.W(16)) u_sat_llen (.din(sum_llen[SW-1:LOG2_WIN]),     .dout(fnext[FEAT_LLEN]));

  logic unused_lo;
  assign unused_lo = ^{sum_x[LOG2_WIN-1:0], sum_abs[LOG2_WIN-1:0],
                       sum_sq[LOG2_WIN+7:0], sum_llen[LOG2_WIN-1:0]};

  // Epoch datapath; the load edge starts a fresh epoch with nothing carried over.
  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      cnt       <= '0;
      sum_x     <= '0;
      sum_abs   <= '0;
      sum_sq    <= '0;
      sum_llen  <= '0;
      max_x     <= '0;
      min_x     <= '0;
      prev_x    <= '0;
      have_prev <= 1'b0;
      zc        <= '0;
    end else if (take) begin
      cnt       <= cnt + 1'b1;
      sum_x     <= sum_x + SW'(x);
      sum_abs   <= sum_abs + SW'(xabs);
      sum_sq    <= sum_sq + QW'(unsigned'(xsq));
      prev_x    <= x;
      have_prev <= 1'b1;
      if (!have_prev) begin
        max_x <= x;
        min_x <= x;
      end else begin
        if (x > max_x) max_x <= x;
        if (x < min_x) min_x <= x;
        if (x[15] != prev_x[15]) zc <= zc + 1'b1;
        sum_llen <= sum_llen + SW'(dabs);
      end
    end
  end

  // A load in FIN wins over the downstream acceptance clearing feat_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACC;
      feat_valid <= 1'b0;
      feature0   <= '0;
      feature1   <= '0;
      feature2   <= '0;
      feature3   <= '0;
      feature4   <= '0;
      feature5   <= '0;
      feature6   <= '0;
      feature7   <= '0;
    end else begin
      if (feat_valid && feat_ready) feat_valid <= 1'b0;
      case (state)
        ACC: begin
          if (take && cnt == '1) state <= FIN;
        end
        FIN: begin
          if (load) begin
            state      <= ACC;
            feat_valid <= 1'b1;
            feature0   <= fnext[FEAT_MEAN];
            feature1   <= fnext[FEAT_MABS];
            feature2   <= fnext[FEAT_MSQ];
            feature3   <= fnext[FEAT_MAX];
            feature4   <= fnext[FEAT_MIN];
            feature5   <= fnext[FEAT_P2P];
            feature6   <= fnext[FEAT_ZC];
            feature7   <= fnext[FEAT_LLEN];
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_eeg_epoch_features.sv
// Directed, table-driven bench for eeg_epoch_features at LOG2_WIN=2.
// Expected values follow FEAT_SAT_EN when that macro is defined.
module tb_eeg_epoch_features;

  localparam int LW = 2;
  localparam int N  = 4;
  localparam int NV = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        feat_valid;
  logic        feat_ready;
  logic [15:0] feature0, feature1, feature2, feature3;
  logic [15:0] feature4, feature5, feature6, feature7;
  logic [15:0] feats [8];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] smp [4];
    logic [15:0] exp [8];
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  eeg_epoch_features #(.LOG2_WIN(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .feature0   (feature0),
    .feature1   (feature1),
    .feature2   (feature2),
    .feature3   (feature3),
    .feature4   (feature4),
    .feature5   (feature5),
    .feature6   (feature6),
    .feature7   (feature7)
  );

  assign feats[0] = feature0;
  assign feats[1] = feature1;
  assign feats[2] = feature2;
  assign feats[3] = feature3;
  assign feats[4] = feature4;
  assign feats[5] = feature5;
  assign feats[6] = feature6;
  assign feats[7] = feature7;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_features(input int v, input string tag);
    for (int i = 0; i < 8; i++)
      check_output($sformatf("%s f%0d", tag, i), feats[i], vecs[v].exp[i]);
  endtask

  // Present one sample and hold it until the edge that accepts it.
  task automatic send_sample(input logic [15:0] d, input bit gap);
    int tries;
    if (gap) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    tries   = 0;
    while (s_ready !== 1'b1 && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (s_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake timeout: s_ready %b expected 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input int v, input bit gaps);
    for (int i = 0; i < N; i++)
      send_sample(vecs[v].smp[i], gaps ? bit'($urandom_range(0, 1)) : 1'b0);
  endtask

  initial begin
    vecs[0].smp = '{16'h0100, 16'hFF00, 16'h0200, 16'hFE00};
    vecs[0].exp = '{16'h0000, 16'h0180, 16'h0280, 16'h0200,
                    16'hFE00, 16'h0400, 16'h0003, 16'h0240};
    vecs[1].smp = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
`ifdef FEAT_SAT_EN
    vecs[1].exp = '{16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                    16'h8000, 16'h7FFF, 16'h0003, 16'h7FFF};
`else
    vecs[1].exp = '{16'hFFFF, 16'h7FFF, 16'hFF80, 16'h7FFF,
                    16'h8000, 16'hFFFF, 16'h0003, 16'hBFFF};
`endif
    vecs[2].smp = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
    vecs[2].exp = '{16'h0080, 16'h0080, 16'h0040, 16'h0080,
                    16'h0080, 16'h0000, 16'h0000, 16'h0000};
    vecs[3].smp = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
    vecs[3].exp = '{16'h0000, 16'h0001, 16'h0000, 16'h0001,
                    16'hFFFF, 16'h0002, 16'h0003, 16'h0001};
    vecs[4].smp = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    vecs[4].exp = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                    16'hFFFF, 16'h0001, 16'h0001, 16'h0000};

    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    feat_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_output("reset feat_valid", 16'(feat_valid), 16'h0000);
    check_output("reset s_ready", 16'(s_ready), 16'h0001);
    for (int i = 0; i < 8; i++)
      check_output($sformatf("reset f%0d", i), feats[i], 16'h0000);

    for (int v = 0; v < NV; v++) begin
      apply_stimulus(v, 1'b0);
      check_output($sformatf("vec%0d fin feat_valid", v), 16'(feat_valid), 16'h0000);
      check_output($sformatf("vec%0d fin s_ready", v), 16'(s_ready), 16'h0000);
      @(negedge clk);
      check_output($sformatf("vec%0d feat_valid", v), 16'(feat_valid), 16'h0001);
      check_output($sformatf("vec%0d s_ready", v), 16'(s_ready), 16'h0001);
      check_features(v, $sformatf("vec%0d", v));
    end

    @(negedge clk);
    check_output("feat_valid cleared", 16'(feat_valid), 16'h0000);

    // Downstream stall across two epochs.
    feat_ready = 1'b0;
    apply_stimulus(0, 1'b0);
    @(negedge clk);
    check_output("stall first valid", 16'(feat_valid), 16'h0001);
    apply_stimulus(2, 1'b0);
    repeat (3) @(negedge clk);
    check_output("stall s_ready", 16'(s_ready), 16'h0000);
    check_output("stall feat_valid", 16'(feat_valid), 16'h0001);
    check_features(0, "stall hold");
    feat_ready = 1'b1;
    @(negedge clk);
    check_output("release feat_valid", 16'(feat_valid), 16'h0001);
    check_output("release s_ready", 16'(s_ready), 16'h0001);
    check_features(2, "release");
    @(negedge clk);
    check_output("release cleared", 16'(feat_valid), 16'h0000);

    // Random s_valid gaps must not change the result.
    apply_stimulus(0, 1'b1);
    @(negedge clk);
    check_output("gaps feat_valid", 16'(feat_valid), 16'h0001);
    check_features(0, "gaps");
    @(negedge clk);

    // Mid-epoch reset discards the partial epoch.
    send_sample(vecs[2].smp[0], 1'b0);
    send_sample(vecs[2].smp[1], 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("midrst feat_valid", 16'(feat_valid), 16'h0000);
    check_output("midrst s_ready", 16'(s_ready), 16'h0001);
    for (int i = 0; i < 8; i++)
      check_output($sformatf("midrst f%0d", i), feats[i], 16'h0000);
    apply_stimulus(0, 1'b0);
    @(negedge clk);
    check_output("postrst feat_valid", 16'(feat_valid), 16'h0001);
    check_features(0, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
